res_station: RTL and testbench

- Reservation station for the Tomasulo core; the receiving end of the decoder's RS dispatch interface (is_rs, rs_pc, rs_op, rs_imm, rs_iQi/Qi, rs_iQj/Qj, rs_Vi/Vj, rs_Qdest).
- Buffers dispatched ALU/branch/jalr instructions and snoops the ALU and LSB result broadcasts (CDB) for pending operands.
- Issues one ready instruction per cycle to the ALU.
- Drives rs_full back to the decoder for stall control.

---
 rtl/res_station.sv | 198 +++++++++++++++++++
 tb/tb_res_station.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_station.sv
// Tomasulo reservation station: buffers dispatched ALU/branch/jalr instructions,
// snoops the ALU and LSB result buses, and issues the lowest-index ready entry each cycle.
`ifndef ROB_R
`define ROB_R 3:0
`endif

module res_station #(
    parameter int RS_SIZE = 8,
    parameter int RS_W    = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            rob_clear,

    input  logic            is_rs,
    input  logic [31:0]     rs_pc,
    input  logic [10:0]     rs_op,
    input  logic [31:0]     rs_imm,
    input  logic            rs_iQi,
    input  logic [`ROB_R]   rs_Qi,
    input  logic [31:0]     rs_Vi,
    input  logic            rs_iQj,
    input  logic [`ROB_R]   rs_Qj,
    input  logic [31:0]     rs_Vj,
    input  logic [`ROB_R]   rs_Qdest,
    output logic            rs_full,

    input  logic            alu_cdb_en,
    input  logic [`ROB_R]   alu_cdb_id,
    input  logic [31:0]     alu_cdb_val,
    input  logic            lsb_cdb_en,
    input  logic [`ROB_R]   lsb_cdb_id,
    input  logic [31:0]     lsb_cdb_val,

    output logic            alu_en,
    output logic [10:0]     alu_op,
    output logic [31:0]     alu_v1,
    output logic [31:0]     alu_v2,
    output logic [31:0]     alu_imm,
    output logic [31:0]     alu_pc,
    output logic [`ROB_R]   alu_dest
);

    localparam int CW = RS_W + 2;

    // Entry state: busy is the only field that needs a reset value.
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] rdy1;
    logic [RS_SIZE-1:0] rdy2;
    logic [31:0]        ent_pc   [RS_SIZE];
    logic [10:0]        ent_op   [RS_SIZE];
    logic [31:0]        ent_imm  [RS_SIZE];
    logic [`ROB_R]      ent_q1   [RS_SIZE];
    logic [31:0]        ent_v1   [RS_SIZE];
    logic [`ROB_R]      ent_q2   [RS_SIZE];
    logic [31:0]        ent_v2   [RS_SIZE];
    logic [`ROB_R]      ent_dest [RS_SIZE];

    logic               free_found;
    logic [RS_W-1:0]    free_idx;
    logic               issue_found;
    logic [RS_W-1:0]    issue_idx;
    logic [RS_W:0]      busy_count;

    logic               d_rdy1;
    logic [31:0]        d_v1;
    logic               d_rdy2;
    logic [31:0]        d_v2;

    logic               do_alloc;

    // Free-slot and issue pick both look at start-of-cycle state only.
    always_comb begin
        // NOTE: every variable is defaulted before the loop so no path can infer a latch.
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        busy_count  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_W'(i);
            end
            if (busy[i] && rdy1[i] && rdy2[i] && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = RS_W'(i);
            end
            busy_count = busy_count + (RS_W+1)'(busy[i]);
        end
    end

    // One slot of headroom covers the decoder's registered dispatch skid.
    assign rs_full = (CW'(busy_count) + CW'(is_rs)) >= CW'(RS_SIZE - 1);

    // Operand capture at dispatch, including a same-cycle broadcast (ALU bus wins).
    always_comb begin
        d_rdy1 = rs_iQi;
        d_v1   = rs_Vi;
        if (!rs_iQi) begin
            if (alu_cdb_en && alu_cdb_id == rs_Qi) begin
                d_rdy1 = 1'b1;
                d_v1   = alu_cdb_val;
            end else if (lsb_cdb_en && lsb_cdb_id == rs_Qi) begin
                d_rdy1 = 1'b1;
                d_v1   = lsb_cdb_val;
            end
        end
        d_rdy2 = rs_iQj;
        d_v2   = rs_Vj;
        if (!rs_iQj) begin
            if (alu_cdb_en && alu_cdb_id == rs_Qj) begin
                d_rdy2 = 1'b1;
                d_v2   = alu_cdb_val;
            end else if (lsb_cdb_en && lsb_cdb_id == rs_Qj) begin
                d_rdy2 = 1'b1;
                d_v2   = lsb_cdb_val;
            end
        end
    end

    // A dispatch into a full station is dropped; the decoder must not send one.
    assign do_alloc = is_rs && free_found;

    // Occupancy and ALU issue register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy     <= '0;
            alu_en   <= 1'b0;
            alu_op   <= '0;
            alu_v1   <= '0;
            alu_v2   <= '0;
            alu_imm  <= '0;
            alu_pc   <= '0;
            alu_dest <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                busy   <= '0;
                alu_en <= 1'b0;
            end else begin
                // NOTE: non-blocking updates let issue-free and allocate touch busy at one edge.
                alu_en <= issue_found;
                if (issue_found) begin
                    busy[issue_idx] <= 1'b0;
                    alu_op          <= ent_op[issue_idx];
                    alu_v1          <= ent_v1[issue_idx];
                    alu_v2          <= ent_v2[issue_idx];
                    alu_imm         <= ent_imm[issue_idx];
                    alu_pc          <= ent_pc[issue_idx];
                    alu_dest        <= ent_dest[issue_idx];
                end
                if (do_alloc) begin
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; busy alone decides whether its contents mean anything.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rdy1[i]) begin
                    if (alu_cdb_en && alu_cdb_id == ent_q1[i]) begin
                        rdy1[i]   <= 1'b1;
                        ent_v1[i] <= alu_cdb_val;
                    end else if (lsb_cdb_en && lsb_cdb_id == ent_q1[i]) begin
                        rdy1[i]   <= 1'b1;
                        ent_v1[i] <= lsb_cdb_val;
                    end
                end
                if (busy[i] && !rdy2[i]) begin
                    if (alu_cdb_en && alu_cdb_id == ent_q2[i]) begin
                        rdy2[i]   <= 1'b1;
                        ent_v2[i] <= alu_cdb_val;
                    end else if (lsb_cdb_en && lsb_cdb_id == ent_q2[i]) begin
                        rdy2[i]   <= 1'b1;
                        ent_v2[i] <= lsb_cdb_val;
                    end
                end
            end
            if (do_alloc) begin
                ent_pc[free_idx]   <= rs_pc;
                ent_op[free_idx]   <= rs_op;
                ent_imm[free_idx]  <= rs_imm;
                rdy1[free_idx]     <= d_rdy1;
                ent_q1[free_idx]   <= rs_Qi;
                ent_v1[free_idx]   <= d_v1;
                rdy2[free_idx]     <= d_rdy2;
                ent_q2[free_idx]   <= rs_Qj;
                ent_v2[free_idx]   <= d_v2;
                ent_dest[free_idx] <= rs_Qdest;
            end
        end
    end

endmodule

// File: tb/tb_res_station.sv
// Self-checking bench for res_station: directed vectors, hand-written corner sequences,
// and a randomized run against a slot-level behavioural model.
`ifndef ROB_R
`define ROB_R 3:0
`endif

module tb_res_station;

    localparam int RS_SIZE = 8;
    localparam int RS_W    = 3;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, rob_clear, is_rs;
    logic [31:0]   rs_pc, rs_imm, rs_Vi, rs_Vj;
    logic [10:0]   rs_op;
    logic          rs_iQi, rs_iQj;
    logic [`ROB_R] rs_Qi, rs_Qj, rs_Qdest;
    logic          rs_full;
    logic          alu_cdb_en, lsb_cdb_en;
    logic [`ROB_R] alu_cdb_id, lsb_cdb_id;
    logic [31:0]   alu_cdb_val, lsb_cdb_val;
    logic          alu_en;
    logic [10:0]   alu_op;
    logic [31:0]   alu_v1, alu_v2, alu_imm, alu_pc;
    logic [`ROB_R] alu_dest;

    res_station #(.RS_SIZE(RS_SIZE), .RS_W(RS_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .is_rs(is_rs), .rs_pc(rs_pc), .rs_op(rs_op), .rs_imm(rs_imm),
        .rs_iQi(rs_iQi), .rs_Qi(rs_Qi), .rs_Vi(rs_Vi),
        .rs_iQj(rs_iQj), .rs_Qj(rs_Qj), .rs_Vj(rs_Vj),
        .rs_Qdest(rs_Qdest), .rs_full(rs_full),
        .alu_cdb_en(alu_cdb_en), .alu_cdb_id(alu_cdb_id), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_id(lsb_cdb_id), .lsb_cdb_val(lsb_cdb_val),
        .alu_en(alu_en), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_dest(alu_dest)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        is_rs      = 1'b0;
        rob_clear  = 1'b0;
        alu_cdb_en = 1'b0;
        lsb_cdb_en = 1'b0;
    endtask

    task automatic set_disp(input logic [31:0] pc, input logic [10:0] op, input logic [31:0] imm,
                            input logic iqi, input logic [3:0] qi, input logic [31:0] vi,
                            input logic iqj, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] dest);
        is_rs = 1'b1; rs_pc = pc; rs_op = op; rs_imm = imm;
        rs_iQi = iqi; rs_Qi = qi; rs_Vi = vi;
        rs_iQj = iqj; rs_Qj = qj; rs_Vj = vj;
        rs_Qdest = dest;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          busy;
        logic [31:0] pc, imm, v1, v2;
        logic [10:0] op;
        bit          r1, r2;
        logic [3:0]  q1, q2, dest;
    } ment_t;

    ment_t       m [RS_SIZE];
    logic        m_en;
    logic [10:0] m_op;
    logic [31:0] m_v1, m_v2, m_imm, m_pc;
    logic [3:0]  m_dest;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
        m_en = 1'b0; m_op = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0; m_dest = '0;
    endfunction

    // Value of a tag on the result buses this cycle; ALU bus takes precedence.
    function automatic bit bus_has(input logic [3:0] tag, output logic [31:0] val);
        val = '0;
        if (alu_cdb_en && alu_cdb_id == tag) begin val = alu_cdb_val; return 1'b1; end
        if (lsb_cdb_en && lsb_cdb_id == tag) begin val = lsb_cdb_val; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic void m_step();
        ment_t       nxt [RS_SIZE];
        int          iss = -1;
        int          fr  = -1;
        logic [31:0] val;
        if (!rdy_in) return;
        if (rob_clear) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            m_en = 1'b0;
            return;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && m[i].r1 && m[i].r2) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        nxt = m;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m[i].busy && !m[i].r1 && bus_has(m[i].q1, val)) begin nxt[i].r1 = 1'b1; nxt[i].v1 = val; end
            if (m[i].busy && !m[i].r2 && bus_has(m[i].q2, val)) begin nxt[i].r2 = 1'b1; nxt[i].v2 = val; end
        end
        m_en = (iss >= 0);
        if (iss >= 0) begin
            m_op = m[iss].op; m_v1 = m[iss].v1; m_v2 = m[iss].v2;
            m_imm = m[iss].imm; m_pc = m[iss].pc; m_dest = m[iss].dest;
            nxt[iss].busy = 1'b0;
        end
        if (is_rs && fr >= 0) begin
            nxt[fr].busy = 1'b1;
            nxt[fr].pc = rs_pc; nxt[fr].op = rs_op; nxt[fr].imm = rs_imm; nxt[fr].dest = rs_Qdest;
            nxt[fr].q1 = rs_Qi; nxt[fr].r1 = rs_iQi; nxt[fr].v1 = rs_Vi;
            nxt[fr].q2 = rs_Qj; nxt[fr].r2 = rs_iQj; nxt[fr].v2 = rs_Vj;
            if (!rs_iQi && bus_has(rs_Qi, val)) begin nxt[fr].r1 = 1'b1; nxt[fr].v1 = val; end
            if (!rs_iQj && bus_has(rs_Qj, val)) begin nxt[fr].r2 = 1'b1; nxt[fr].v2 = val; end
        end
        m = nxt;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        iqi; logic [3:0] qi; logic [31:0] vi;
        logic        iqj; logic [3:0] qj; logic [31:0] vj;
        logic [1:0]  cdb; logic [3:0] cid; logic [31:0] cval;  // cdb: 0 none, 1 ALU, 2 LSB
        logic        exp_issue; logic [31:0] exp_v1; logic [31:0] exp_v2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 4'd0, 32'd5,     1'b1, 4'd0, 32'd7,  2'd0, 4'd0, 32'd0,      1'b1, 32'd5,      32'd7};
        vecs[1] = '{1'b1, 4'd0, 32'd3,     1'b0, 4'd2, 32'd0,  2'd1, 4'd2, 32'd9,      1'b1, 32'd3,      32'd9};
        vecs[2] = '{1'b0, 4'd4, 32'd0,     1'b1, 4'd0, 32'd11, 2'd2, 4'd4, 32'hAB,     1'b1, 32'hAB,     32'd11};
        vecs[3] = '{1'b0, 4'd5, 32'd0,     1'b1, 4'd0, 32'd1,  2'd1, 4'd6, 32'h77,     1'b0, 32'd0,      32'd0};
        vecs[4] = '{1'b1, 4'd2, 32'h64,    1'b1, 4'd0, 32'd2,  2'd1, 4'd2, 32'd99,     1'b1, 32'h64,     32'd2};
        vecs[5] = '{1'b0, 4'd7, 32'd0,     1'b0, 4'd7, 32'd0,  2'd1, 4'd7, 32'hDEAD,   1'b1, 32'hDEAD,   32'hDEAD};

        rst_in = 1'b1; rdy_in = 1'b1; idle();
        rs_pc = '0; rs_op = '0; rs_imm = '0; rs_iQi = 1'b0; rs_Qi = '0; rs_Vi = '0;
        rs_iQj = 1'b0; rs_Qj = '0; rs_Vj = '0; rs_Qdest = '0;
        alu_cdb_id = '0; alu_cdb_val = '0; lsb_cdb_id = '0; lsb_cdb_val = '0;
        m_reset();

        // Reset state
        #12;
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_v1", alu_v1, 32'd0);
        check("rst_alu_pc", alu_pc, 32'd0);
        check("rst_alu_dest", 32'(alu_dest), 32'd0);
        check("rst_rs_full", 32'(rs_full), 32'd0);
        tick();
        rst_in = 1'b0;

        // Table-driven single-dispatch vectors
        for (int i = 0; i < 6; i++) begin
            set_disp(32'h1000 + 32'(i * 4), 11'h033, 32'(i), vecs[i].iqi, vecs[i].qi, vecs[i].vi,
                     vecs[i].iqj, vecs[i].qj, vecs[i].vj, 4'(i));
            alu_cdb_en = (vecs[i].cdb == 2'd1); alu_cdb_id = vecs[i].cid; alu_cdb_val = vecs[i].cval;
            lsb_cdb_en = (vecs[i].cdb == 2'd2); lsb_cdb_id = vecs[i].cid; lsb_cdb_val = vecs[i].cval;
            tick(); idle();
            check($sformatf("vec%0d_en_e0", i), 32'(alu_en), 32'd0);
            tick();
            check($sformatf("vec%0d_en_e1", i), 32'(alu_en), 32'(vecs[i].exp_issue));
            if (vecs[i].exp_issue) begin
                check($sformatf("vec%0d_v1", i), alu_v1, vecs[i].exp_v1);
                check($sformatf("vec%0d_v2", i), alu_v2, vecs[i].exp_v2);
                check($sformatf("vec%0d_dest", i), 32'(alu_dest), 32'(i));
                check($sformatf("vec%0d_op", i), 32'(alu_op), 32'h033);
                check($sformatf("vec%0d_pc", i), alu_pc, 32'h1000 + 32'(i * 4));
                check($sformatf("vec%0d_imm", i), alu_imm, 32'(i));
            end
            tick();
            check($sformatf("vec%0d_en_e2", i), 32'(alu_en), 32'd0);
            rob_clear = 1'b1; tick(); rob_clear = 1'b0;
        end

        // Operand arrives on the ALU bus two cycles after dispatch
        set_disp(32'h2000, 11'h013, 32'd0, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd1, 4'd1);
        tick(); idle();
        check("late_en_e0", 32'(alu_en), 32'd0);
        tick();
        check("late_en_e1", 32'(alu_en), 32'd0);
        alu_cdb_en = 1'b1; alu_cdb_id = 4'd6; alu_cdb_val = 32'h1234;
        tick(); idle();
        check("late_en_bcast", 32'(alu_en), 32'd0);
        tick();
        check("late_en_issue", 32'(alu_en), 32'd1);
        check("late_v1", alu_v1, 32'h1234);
        tick();

        // Fill with 7 entries waiting on tag 9, then release them with one broadcast
        for (int k = 0; k < 7; k++) begin
            set_disp(32'h3000 + 32'(k * 4), 11'h033, 32'd0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'(k), 4'(k));
            #1;
            check($sformatf("fill_full_%0d", k), 32'(rs_full), 32'(k >= 6));
            tick();
            check($sformatf("fill_en_%0d", k), 32'(alu_en), 32'd0);
        end
        idle(); #1;
        check("fill_full_idle", 32'(rs_full), 32'd1);
        alu_cdb_en = 1'b1; alu_cdb_id = 4'd9; alu_cdb_val = 32'h55;
        tick(); idle();
        check("fill_en_bcast", 32'(alu_en), 32'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("drain_en_%0d", k), 32'(alu_en), 32'd1);
            check($sformatf("drain_dest_%0d", k), 32'(alu_dest), 32'(k));
            check($sformatf("drain_v1_%0d", k), alu_v1, 32'h55);
            check($sformatf("drain_v2_%0d", k), alu_v2, 32'(k));
        end
        tick();
        check("drain_en_end", 32'(alu_en), 32'd0);
        check("drain_full_end", 32'(rs_full), 32'd0);

        // Flush with 5 pending entries and a concurrent ready dispatch
        for (int k = 0; k < 5; k++) begin
            set_disp(32'h4000, 11'h033, 32'd0, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd0, 4'(k));
            tick();
        end
        set_disp(32'h4100, 11'h033, 32'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd12);
        rob_clear = 1'b1;
        tick(); idle(); #1;
        check("clr_en", 32'(alu_en), 32'd0);
        check("clr_full", 32'(rs_full), 32'd0);
        tick();
        check("clr_dropped", 32'(alu_en), 32'd0);
        alu_cdb_en = 1'b1; alu_cdb_id = 4'd10; alu_cdb_val = 32'd1;
        tick(); idle();
        tick();
        check("clr_no_issue", 32'(alu_en), 32'd0);

        // Mid-cycle reset, then a freeze with a ready entry
        set_disp(32'h5000, 11'h033, 32'd0, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4, 4'd2);
        tick(); idle();
        tick();
        check("arst_pre_en", 32'(alu_en), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        check("arst_en", 32'(alu_en), 32'd0);
        check("arst_v1", alu_v1, 32'd0);
        tick();
        rst_in = 1'b0;
        set_disp(32'h5100, 11'h033, 32'd0, 1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'h22, 4'd5);
        tick(); idle();
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("frz_en_%0d", k), 32'(alu_en), 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        check("frz_issue_en", 32'(alu_en), 32'd1);
        check("frz_issue_v1", alu_v1, 32'h21);
        check("frz_issue_dest", 32'(alu_dest), 32'd5);

        // Randomized run against the model
        rst_in = 1'b1; idle(); m_reset();
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            rob_clear   = ($urandom_range(0, 49) == 0);
            is_rs       = (m_count() < RS_SIZE) && ($urandom_range(0, 9) < 8);
            rs_pc       = $urandom;
            rs_op       = 11'($urandom);
            rs_imm      = $urandom;
            rs_iQi      = 1'($urandom_range(0, 1));
            rs_Qi       = 4'($urandom_range(0, 15));
            rs_Vi       = $urandom;
            rs_iQj      = 1'($urandom_range(0, 1));
            rs_Qj       = 4'($urandom_range(0, 15));
            rs_Vj       = $urandom;
            rs_Qdest    = 4'($urandom_range(0, 15));
            alu_cdb_en  = 1'($urandom_range(0, 1));
            alu_cdb_id  = 4'($urandom_range(0, 15));
            alu_cdb_val = $urandom;
            lsb_cdb_en  = 1'($urandom_range(0, 1));
            lsb_cdb_id  = alu_cdb_id + 4'($urandom_range(1, 15));
            lsb_cdb_val = $urandom;
            #1;
            check($sformatf("rnd%0d_full", c), 32'(rs_full), 32'((m_count() + int'(is_rs)) >= RS_SIZE - 1));
            assert (!(rdy_in && !rob_clear && is_rs && m_count() == RS_SIZE))
                else $error("dispatch into a full reservation station at cycle %0d", c);
            m_step();
            tick();
            check($sformatf("rnd%0d_en", c), 32'(alu_en), 32'(m_en));
            check($sformatf("rnd%0d_op", c), 32'(alu_op), 32'(m_op));
            check($sformatf("rnd%0d_v1", c), alu_v1, m_v1);
            check($sformatf("rnd%0d_v2", c), alu_v2, m_v2);
            check($sformatf("rnd%0d_imm", c), alu_imm, m_imm);
            check($sformatf("rnd%0d_pc", c), alu_pc, m_pc);
            check($sformatf("rnd%0d_dest", c), 32'(alu_dest), 32'(m_dest));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
